uart_rx_fifo: RTL and testbench

Receive-side buffer between rx_engine and the tramelblaze IN_PORT/interrupt path.
- Captures each byte rx_engine presents on RXRDY, together with its FERR/PERR/OVF flags.
- Returns the clr handshake to rx_engine.
- Queues entries in a DEPTH-entry FIFO and raises an interrupt to the processor.
- Processor pops data and reads status through port_id-decoded reads.

---
 rtl/uart_rx_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive buffer between rx_engine and the processor port bus.
//               Optional fill-level read port: UART_RXF_LEVEL_PORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [15:0] DATA_PORT  = 16'h0000,
    parameter logic [15:0] STAT_PORT  = 16'h0001,
    parameter logic [15:0] LEVEL_PORT = 16'h0002
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxrdy,
    input  logic [7:0]  rx_data,
    input  logic        ferr,
    input  logic        perr,
    input  logic        ovf,
    output logic        clr,
    input  logic [15:0] port_id,
    input  logic        read_strobe,
    output logic [7:0]  in_port,
    output logic        interrupt,
    input  logic        int_ack
);

    localparam int                    c_depth       = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] c_ptr_one     = 1;
    localparam logic [DEPTH_LOG2:0]   c_cnt_one     = 1;
    localparam logic [0:0]            c_st_idle     = 1'b0;
    localparam logic [0:0]            c_st_wait_low = 1'b1;

    logic [0:0]            r_state;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_fifo_ovr;
    logic                  r_interrupt;
    logic                  r_clr;
    logic [10:0]           r_mem [c_depth];

    logic                  w_empty;
    logic                  w_full;
    logic                  w_half;
    logic                  w_pop;
    logic                  w_stat_rd;
    logic                  w_req;
    logic                  w_push;
    logic                  w_drop;
    logic [10:0]           w_head;
    logic [7:0]            w_status;

    // count never exceeds DEPTH, so its top two bits give full and >= DEPTH/2
    assign w_empty   = (r_count == '0);
    assign w_full    = r_count[DEPTH_LOG2];
    assign w_half    = r_count[DEPTH_LOG2] | r_count[DEPTH_LOG2-1];

    assign w_pop     = read_strobe && (port_id == DATA_PORT) && !w_empty;
    assign w_stat_rd = read_strobe && (port_id == STAT_PORT);

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
    assign w_req     = (r_state == c_st_idle) && rxrdy;
    assign w_push    = w_req && (!w_full || w_pop);
    assign w_drop    = w_req && !w_push;

    assign w_head    = r_mem[r_rd_ptr];
    assign w_status  = {r_fifo_ovr,
                        (w_empty ? 3'b000 : w_head[10:8]),
                        w_full, w_half, 1'b0, !w_empty};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {ferr, perr, ovf, rx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_fifo_ovr  <= 1'b0;
            r_interrupt <= 1'b0;
            r_clr       <= 1'b0;
        end else begin
            r_clr <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (rxrdy) begin
                        r_clr   <= 1'b1;
                        r_state <= c_st_wait_low;
                    end
                end
                c_st_wait_low: begin
                    if (!rxrdy) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase

            if (w_drop) begin
                r_fifo_ovr <= 1'b1;
            end else if (w_stat_rd) begin
                r_fifo_ovr <= 1'b0;
            end

            // Set has priority so a push coinciding with an ack is not lost
            if (w_push) begin
                r_interrupt <= 1'b1;
            end else if (int_ack) begin
                r_interrupt <= 1'b0;
            end
        end
    end

    always_comb begin
        in_port = 8'h00;
        if (port_id == DATA_PORT) begin
            in_port = w_empty ? 8'h00 : w_head[7:0];
        end else if (port_id == STAT_PORT) begin
            in_port = w_status;
        end else if (port_id == LEVEL_PORT) begin
`ifdef UART_RXF_LEVEL_PORT_EN
            in_port = 8'(r_count);
`else
            in_port = 8'h00;
`endif
        end
    end

    assign clr       = r_clr;
    assign interrupt = r_interrupt;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam logic [15:0] c_data  = 16'h0000;
    localparam logic [15:0] c_stat  = 16'h0001;
    localparam logic [15:0] c_level = 16'h0002;
    localparam logic [15:0] c_unmap = 16'h00F0;
    localparam int          c_depth = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        rxrdy;
    logic [7:0]  rx_data;
    logic        ferr;
    logic        perr;
    logic        ovf;
    logic        clr;
    logic [15:0] port_id;
    logic        read_strobe;
    logic [7:0]  in_port;
    logic        interrupt;
    logic        int_ack;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: queue of {ferr,perr,ovf,data} entries plus flags
    logic [10:0] q[$];
    logic        m_ovr   = 1'b0;
    logic        m_irq   = 1'b0;
    logic        m_clr   = 1'b0;
    logic        m_armed = 1'b1;
    logic        mon_en  = 1'b0;

    uart_rx_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .rxrdy      (rxrdy),
        .rx_data    (rx_data),
        .ferr       (ferr),
        .perr       (perr),
        .ovf        (ovf),
        .clr        (clr),
        .port_id    (port_id),
        .read_strobe(read_strobe),
        .in_port    (in_port),
        .interrupt  (interrupt),
        .int_ack    (int_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_port(input logic [15:0] pid);
        logic [10:0] h;
        logic        ne;
        ne = (q.size() != 0);
        h  = ne ? q[0] : 11'h000;
        if (pid == c_data) return h[7:0];
        if (pid == c_stat)
            return {m_ovr, h[10:8], (q.size() == c_depth), (q.size() >= c_depth / 2), 1'b0, ne};
`ifdef UART_RXF_LEVEL_PORT_EN
        if (pid == c_level) return 8'(q.size());
`endif
        return 8'h00;
    endfunction

    // One clock: derive the model's next state from the inputs now applied
    task automatic tick();
        logic        do_rst, pop, sread, preq, push, drop, rx_s, ack_s;
        logic [10:0] ent;
        do_rst = reset;
        pop    = read_strobe && (port_id == c_data) && (q.size() != 0);
        sread  = read_strobe && (port_id == c_stat);
        preq   = m_armed && rxrdy;
        push   = preq && ((q.size() < c_depth) || pop);
        drop   = preq && !push;
        rx_s   = rxrdy;
        ack_s  = int_ack;
        ent    = {ferr, perr, ovf, rx_data};
        @(posedge clk);
        if (do_rst) begin
            q.delete();
            m_ovr   = 1'b0;
            m_irq   = 1'b0;
            m_clr   = 1'b0;
            m_armed = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(ent);
            if (drop) m_ovr = 1'b1;
            else if (sread) m_ovr = 1'b0;
            if (push) m_irq = 1'b1;
            else if (ack_s) m_irq = 1'b0;
            m_clr = preq;
            if (preq) m_armed = 1'b0;
            else if (!rx_s) m_armed = 1'b1;
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            if (clr !== m_clr || interrupt !== m_irq) begin
                $display("FAIL clr_irq_monitor: clr=%b interrupt=%b, expected clr=%b interrupt=%b at %0t",
                         clr, interrupt, m_clr, m_irq, $time);
                miscompares++;
            end
        end
    end

    task automatic push_byte(input logic [7:0] d, input logic [2:0] fl);
        rx_data = d;
        {ferr, perr, ovf} = fl;
        rxrdy = 1'b1;
        tick();
        rxrdy = 1'b0;
        tick();
    endtask

    task automatic drive_read(input logic [15:0] pid);
        port_id     = pid;
        read_strobe = 1'b1;
        #1;
    endtask

    task automatic release_read();
        tick();
        read_strobe = 1'b0;
        port_id     = c_unmap;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        reset = 1'b0;
        drive_read(c_stat);
        vectors++;
        if (in_port !== 8'h00 || interrupt !== 1'b0 || clr !== 1'b0) begin
            $display("FAIL reset_state: status=%h irq=%b clr=%b, expected 00/0/0", in_port, interrupt, clr);
            miscompares++;
        end
        release_read();
    endtask

    task automatic test_single();
        rx_data = 8'hA5;
        {ferr, perr, ovf} = 3'b010;
        rxrdy = 1'b1;
        tick();
        vectors++;
        if (clr !== 1'b1 || interrupt !== 1'b1) begin
            $display("FAIL single_clr_irq: clr=%b irq=%b, expected 1/1", clr, interrupt);
            miscompares++;
        end
        rxrdy = 1'b0;
        tick();
        vectors++;
        if (clr !== 1'b0) begin
            $display("FAIL single_clr_pulse: clr=%b, expected 0", clr);
            miscompares++;
        end
        drive_read(c_stat);
        vectors++;
        if (in_port !== 8'h21) begin
            $display("FAIL single_status: got %h, expected 21", in_port);
            miscompares++;
        end
        release_read();
        drive_read(c_data);
        vectors++;
        if (in_port !== 8'hA5) begin
            $display("FAIL single_data: got %h, expected a5", in_port);
            miscompares++;
        end
        release_read();
        drive_read(c_stat);
        vectors++;
        if (in_port !== 8'h00) begin
            $display("FAIL single_status_after: got %h, expected 00", in_port);
            miscompares++;
        end
        release_read();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) push_byte(8'(i), 3'b000);
        drive_read(c_stat);
        vectors++;
        if (in_port !== 8'h0D) begin
            $display("FAIL fill_status_full: got %h, expected 0d", in_port);
            miscompares++;
        end
        port_id = c_unmap;
        read_strobe = 1'b0;
        push_byte(8'hFF, 3'b111);
        drive_read(c_stat);
        vectors++;
        if (in_port !== 8'h8D) begin
            $display("FAIL fill_status_drop: got %h, expected 8d", in_port);
            miscompares++;
        end
        release_read();
        for (int i = 0; i < 16; i++) begin
            drive_read(c_data);
            vectors++;
            if (in_port !== 8'(i)) begin
                $display("FAIL fill_read_order[%0d]: got %h, expected %h", i, in_port, 8'(i));
                miscompares++;
            end
            release_read();
        end
        drive_read(c_stat);
        vectors++;
        if (in_port !== 8'h00) begin
            $display("FAIL fill_ovr_cleared: got %h, expected 00", in_port);
            miscompares++;
        end
        release_read();
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) push_byte(8'(8'h30 + i), 3'b000);
        rx_data = 8'h55;
        {ferr, perr, ovf} = 3'b000;
        rxrdy = 1'b1;
        drive_read(c_data);
        vectors++;
        if (in_port !== 8'h30) begin
            $display("FAIL fullpp_head: got %h, expected 30", in_port);
            miscompares++;
        end
        release_read();
        rxrdy = 1'b0;
        tick();
        drive_read(c_stat);
        vectors++;
        if (in_port !== 8'h0D || in_port !== exp_port(c_stat)) begin
            $display("FAIL fullpp_status: got %h, expected 0d", in_port);
            miscompares++;
        end
        release_read();
        for (int i = 0; i < 16; i++) begin
            drive_read(c_data);
            vectors++;
            if (in_port !== exp_port(c_data) || (i == 15 && in_port !== 8'h55)) begin
                $display("FAIL fullpp_read[%0d]: got %h, expected %h", i, in_port, exp_port(c_data));
                miscompares++;
            end
            release_read();
        end
    endtask

    task automatic test_interrupt();
        int_ack = 1'b1;
        tick();
        rx_data = 8'h3C;
        {ferr, perr, ovf} = 3'b100;
        rxrdy = 1'b1;
        tick();
        vectors++;
        if (interrupt !== 1'b1) begin
            $display("FAIL irq_set_wins: got %b, expected 1", interrupt);
            miscompares++;
        end
        rxrdy   = 1'b0;
        int_ack = 1'b0;
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        vectors++;
        if (interrupt !== 1'b0) begin
            $display("FAIL irq_ack_clears: got %b, expected 0", interrupt);
            miscompares++;
        end
        drive_read(c_data);
        release_read();
        drive_read(c_data);
        vectors++;
        if (in_port !== 8'h00) begin
            $display("FAIL empty_data_read: got %h, expected 00", in_port);
            miscompares++;
        end
        release_read();
        drive_read(c_stat);
        vectors++;
        if (in_port !== 8'h00) begin
            $display("FAIL empty_status: got %h, expected 00", in_port);
            miscompares++;
        end
        release_read();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) push_byte(8'(8'h70 + i), 3'b001);
        rx_data = 8'h74;
        {ferr, perr, ovf} = 3'b000;
        rxrdy = 1'b1;
        tick();
`ifdef UART_RXF_LEVEL_PORT_EN
        drive_read(c_level);
        vectors++;
        if (in_port !== 8'h05) begin
            $display("FAIL level_before_reset: got %h, expected 05", in_port);
            miscompares++;
        end
        release_read();
`endif
        reset = 1'b1;
        rxrdy = 1'b0;
        tick();
        reset = 1'b0;
        drive_read(c_stat);
        vectors++;
        if (in_port !== 8'h00 || interrupt !== 1'b0) begin
            $display("FAIL reset_mid: status=%h irq=%b, expected 00/0", in_port, interrupt);
            miscompares++;
        end
        release_read();
`ifdef UART_RXF_LEVEL_PORT_EN
        drive_read(c_level);
        vectors++;
        if (in_port !== 8'h00) begin
            $display("FAIL level_after_reset: got %h, expected 00", in_port);
            miscompares++;
        end
        release_read();
`endif
    endtask

    task automatic test_random();
        logic [7:0] exp;
        for (int n = 0; n < 600; n++) begin
            rxrdy       = ($urandom_range(0, 2) != 0);
            rx_data     = 8'($urandom);
            {ferr, perr, ovf} = 3'($urandom);
            port_id     = 16'($urandom_range(0, 4));
            read_strobe = ($urandom_range(0, 3) == 0);
            int_ack     = ($urandom_range(0, 9) == 0);
            reset       = ($urandom_range(0, 149) == 0);
            #1;
            exp = exp_port(port_id);
            vectors++;
            if (in_port !== exp) begin
                $display("FAIL random_in_port[%0d]: port=%h got %h, expected %h", n, port_id, in_port, exp);
                miscompares++;
            end
            tick();
        end
        reset       = 1'b0;
        read_strobe = 1'b0;
        rxrdy       = 1'b0;
        int_ack     = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        rxrdy       = 1'b0;
        rx_data     = 8'h00;
        {ferr, perr, ovf} = 3'b000;
        port_id     = c_unmap;
        read_strobe = 1'b0;
        int_ack     = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fill();
        test_full_push_pop();
        test_interrupt();
        test_reset_mid();
        test_random();
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
